// File: rtl/ccff_bitstream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ccff_bitstream_loader : serializes config words LSB-first onto ccff_head and
// gathers the bits leaving ccff_tail into readback words.       Rev 1.0
// ============================================================================
module ccff_bitstream_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk_i,
  input  logic              prog_reset_n_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] cfg_data_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic              ccff_head_o,
  output logic              ccff_clk_en_o,
  input  logic              ccff_tail_i,
  output logic [WORD_W-1:0] rb_data_o,
  output logic              rb_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  bit_count_o
);

  localparam int BUF_CNT_W = $clog2(WORD_W + 1);
  localparam int IDX_W     = $clog2(WORD_W);

  localparam logic [CNT_W-1:0]     CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]     LAST_BIT_C  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX_C  = IDX_W'(WORD_W - 1);
  localparam logic [BUF_CNT_W-1:0] WORD_W_C    = BUF_CNT_W'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [CNT_W-1:0]     bit_count_q, bit_count_d;
  logic [WORD_W-1:0]    buf_q,       buf_d;
  logic [BUF_CNT_W-1:0] buf_cnt_q,   buf_cnt_d;
  logic                 head_q,      head_d;
  logic                 clk_en_q,    clk_en_d;
  logic [WORD_W-1:0]    acc_q,       acc_d;
  logic [IDX_W-1:0]     acc_idx_q,   acc_idx_d;
  logic [WORD_W-1:0]    rb_data_q,   rb_data_d;
  logic                 rb_valid_q,  rb_valid_d;

  logic                 w_shift;
  logic                 w_ready;
  logic                 w_fire;
  logic                 w_last_bit;
  logic [CNT_W-1:0]     w_remain;
  logic [BUF_CNT_W-1:0] w_load_cnt;

  assign w_shift    = (state_q == S_SHIFT) && (buf_cnt_q != '0);
  assign w_ready    = (state_q == S_SHIFT) && (buf_cnt_q == '0) &&
                      (bit_count_q < CHAIN_LEN_C);
  assign w_fire     = w_ready && cfg_valid_i;
  assign w_last_bit = (bit_count_q == LAST_BIT_C);
  assign w_remain   = CHAIN_LEN_C - bit_count_q;

  // The final word of a load only carries the bits still missing from the chain.
  assign w_load_cnt = (32'(w_remain) >= 32'(WORD_W)) ? WORD_W_C
                                                    : BUF_CNT_W'(w_remain);

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    acc_d       = acc_q;
    acc_idx_d   = acc_idx_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_SHIFT;
          bit_count_d = '0;
          buf_cnt_d   = '0;
          acc_d       = '0;
          acc_idx_d   = '0;
        end
      end

      S_SHIFT: begin
        if (w_fire) begin
          buf_d     = cfg_data_i;
          buf_cnt_d = w_load_cnt;
        end else if (w_shift) begin
          buf_d       = buf_q >> 1;
          buf_cnt_d   = buf_cnt_q - BUF_CNT_W'(1);
          bit_count_d = bit_count_q + CNT_W'(1);
          // Tail is sampled before the chain advances on this same edge.
          acc_d[acc_idx_q] = ccff_tail_i;
          if (w_last_bit || (acc_idx_q == LAST_IDX_C)) begin
            rb_data_d  = acc_d;
            rb_valid_d = 1'b1;
            acc_d      = '0;
            acc_idx_d  = '0;
          end else begin
            acc_idx_d  = acc_idx_q + IDX_W'(1);
          end
          if (w_last_bit) begin
            state_d = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Head and enable are precomputed one cycle early so both come straight from
  // flops for the whole shift cycle; head holds its value while starved.
  always_comb begin
    clk_en_d = (state_d == S_SHIFT) && (buf_cnt_d != '0);
    head_d   = clk_en_d ? buf_d[0] : head_q;
  end

  always_ff @(posedge prog_clk_i or negedge prog_reset_n_i) begin
    if (!prog_reset_n_i) begin
      state_q     <= S_IDLE;
      bit_count_q <= '0;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      acc_q       <= '0;
      acc_idx_q   <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      acc_q       <= acc_d;
      acc_idx_q   <= acc_idx_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

  assign cfg_ready_o   = w_ready;
  assign ccff_head_o   = head_q;
  assign ccff_clk_en_o = clk_en_q;
  assign rb_data_o     = rb_data_q;
  assign rb_valid_o    = rb_valid_q;
  assign busy_o        = (state_q == S_SHIFT);
  assign done_o        = (state_q == S_DONE);
  assign bit_count_o   = bit_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ccff_bitstream_loader : drives two loader instances (64- and 40-bit
// chains) with behavioural chain models.                         Rev 1.0
// ============================================================================
module tb_ccff_bitstream_loader;

  localparam int WW  = 32;
  localparam int L   = 64;
  localparam int LP  = 40;
  localparam int TMO = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 64-bit chain instance
  logic          start, cfg_valid, cfg_ready, head, en, tail, rb_valid, busy, done;
  logic [WW-1:0] cfg_data, rb_data;
  logic [6:0]    bit_count;

  // 40-bit chain instance
  logic          start_p, cfg_valid_p, cfg_ready_p, head_p, en_p, tail_p;
  logic          rb_valid_p, busy_p, done_p;
  logic [WW-1:0] cfg_data_p, rb_data_p;
  logic [5:0]    bit_count_p;

  int checks = 0;
  int errors = 0;

  ccff_bitstream_loader #(.WORD_W(WW), .CHAIN_LEN(L)) dut (
    .prog_clk_i(clk), .prog_reset_n_i(rst_n), .start_i(start),
    .cfg_data_i(cfg_data), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .ccff_head_o(head), .ccff_clk_en_o(en), .ccff_tail_i(tail),
    .rb_data_o(rb_data), .rb_valid_o(rb_valid), .busy_o(busy), .done_o(done),
    .bit_count_o(bit_count)
  );

  ccff_bitstream_loader #(.WORD_W(WW), .CHAIN_LEN(LP)) dut_p (
    .prog_clk_i(clk), .prog_reset_n_i(rst_n), .start_i(start_p),
    .cfg_data_i(cfg_data_p), .cfg_valid_i(cfg_valid_p), .cfg_ready_o(cfg_ready_p),
    .ccff_head_o(head_p), .ccff_clk_en_o(en_p), .ccff_tail_i(tail_p),
    .rb_data_o(rb_data_p), .rb_valid_o(rb_valid_p), .busy_o(busy_p), .done_o(done_p),
    .bit_count_o(bit_count_p)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Physical chains: head enters at the top, tail is bit 0.
  logic [L-1:0]  chain,   pre_val;
  logic [LP-1:0] chain_p, pre_val_p;
  logic          pre_req = 1'b0, pre_req_p = 1'b0;

  always @(posedge clk) begin
    if (pre_req)  chain <= pre_val;
    else if (en)  chain <= {head, chain[L-1:1]};
    if (pre_req_p) chain_p <= pre_val_p;
    else if (en_p) chain_p <= {head_p, chain_p[LP-1:1]};
  end
  assign tail   = chain[0];
  assign tail_p = chain_p[0];

  int            en_cnt, acc_cnt, viol, en_cnt_p, acc_cnt_p;
  time           last_en_t;
  logic          prev_head;
  logic [WW-1:0] rbq[$];
  logic [WW-1:0] rbq_p[$];

  always @(negedge clk) begin
    if (en) begin en_cnt++; last_en_t = $time; end
    if (cfg_valid && cfg_ready) acc_cnt++;
    if (rb_valid) rbq.push_back(rb_data);
    if (busy && !en && (head !== prev_head)) viol++;
    prev_head = head;
    if (en_p) en_cnt_p++;
    if (cfg_valid_p && cfg_ready_p) acc_cnt_p++;
    if (rb_valid_p) rbq_p.push_back(rb_data_p);
  end

  function automatic logic rdy(input bit b);
    return b ? cfg_ready_p : cfg_ready;
  endfunction

  task automatic drv(input bit b, input logic v, input logic [WW-1:0] d);
    if (b) begin cfg_valid_p = v; cfg_data_p = d; end
    else   begin cfg_valid   = v; cfg_data   = d; end
  endtask

  // Offers one word; with gap>0 the loader is first left starving for gap cycles.
  task automatic send_word(input bit b, input logic [WW-1:0] w, input int gap);
    int n;
    n = 0;
    if (gap > 0) begin
      drv(b, 1'b0, w);
      while (!rdy(b) && n < TMO) begin @(negedge clk); n++; end
      repeat (gap) begin
        @(negedge clk);
        check("starve_en", b ? en_p : en, 1'b0);
      end
    end
    drv(b, 1'b1, w);
    n = 0;
    while (!rdy(b) && n < TMO) begin @(negedge clk); n++; end
    check("accept", rdy(b), 1'b1);
    @(negedge clk);
  endtask

  task automatic run_load(input logic [L-1:0] data, input logic [L-1:0] pre,
                          input int gap0, input int gap1,
                          input bit poke_start, input bit extra_valid);
    int n;
    @(negedge clk);
    pre_val = pre; pre_req = 1'b1;
    en_cnt = 0; acc_cnt = 0; viol = 0; rbq.delete();
    start = 1'b1;
    @(negedge clk);
    pre_req = 1'b0; start = 1'b0;
    check("start_done_low", done, 1'b0);
    check("start_busy", busy, 1'b1);
    check("start_count", bit_count, 0);
    send_word(1'b0, data[31:0], gap0);
    if (poke_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    send_word(1'b0, data[63:32], gap1);
    if (extra_valid) cfg_data = $urandom;
    else             cfg_valid = 1'b0;
    n = 0;
    while (!done && n < TMO) begin @(negedge clk); n++; end
    check("done_tmo", done, 1'b1);
    check("done_latency", 64'($time - last_en_t), 64'd10);
    check("en_cycles", en_cnt, L);
    check("bit_count", bit_count, L);
    check("ready_in_done", cfg_ready, 1'b0);
    check("en_in_done", en, 1'b0);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("chain", chain, data);
    check("words_accepted", acc_cnt, 2);
    check("rb_words", rbq.size(), 2);
    for (int i = 0; i < 2 && i < rbq.size(); i++)
      check("rb_data", rbq[i], pre[i*WW +: WW]);
    check("head_hold", viol, 0);
    check("done_hold", done, 1'b1);
    check("count_hold", bit_count, L);
  endtask

  task automatic run_load_p(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input logic [LP-1:0] pre);
    int n;
    @(negedge clk);
    pre_val_p = pre; pre_req_p = 1'b1;
    en_cnt_p = 0; acc_cnt_p = 0; rbq_p.delete();
    start_p = 1'b1;
    @(negedge clk);
    pre_req_p = 1'b0; start_p = 1'b0;
    send_word(1'b1, w0, 0);
    send_word(1'b1, w1, 0);
    cfg_data_p = $urandom;  // a third word stays offered until DONE
    n = 0;
    while (!done_p && n < TMO) begin @(negedge clk); n++; end
    check("p_done_tmo", done_p, 1'b1);
    check("p_third_ready", cfg_ready_p, 1'b0);
    check("p_en_cycles", en_cnt_p, LP);
    check("p_bit_count", bit_count_p, LP);
    @(negedge clk);
    cfg_valid_p = 1'b0;
    check("p_chain", 64'(chain_p), 64'({w1[7:0], w0}));
    check("p_last_bits", 64'(chain_p[LP-1:WW]), 64'(w1[7:0]));
    check("p_words_accepted", acc_cnt_p, 2);
    check("p_rb_words", rbq_p.size(), 2);
    if (rbq_p.size() == 2) begin
      check("p_rb0", rbq_p[0], pre[WW-1:0]);
      check("p_rb1", rbq_p[1], {24'd0, pre[LP-1:WW]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [L-1:0] d, p;
    start = 0; cfg_valid = 0; cfg_data = '0;
    start_p = 0; cfg_valid_p = 0; cfg_data_p = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", cfg_ready, 1'b0);
    check("rst_head", head, 1'b0);
    check("rst_en", en, 1'b0);
    check("rst_rb_valid", rb_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", bit_count, 0);
    check("rst_rb_data", rb_data, 0);
    check("rst_p_busy", busy_p, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", cfg_ready, 1'b0);

    // Directed full load with readback pattern, then the same data starved.
    run_load(64'h8000_00FF_A5A5_0001, 64'h0123_4567_89AB_CDEF, 0, 0, 1'b0, 1'b0);
    run_load(64'h8000_00FF_A5A5_0001, {$urandom, $urandom}, 5, 5, 1'b0, 1'b0);
    // Start pulsed while shifting is ignored; this load also starts from DONE.
    run_load({$urandom, $urandom}, {$urandom, $urandom}, 0, 2, 1'b1, 1'b1);

    // Asynchronous reset after 17 shifts.
    @(negedge clk);
    pre_val = {$urandom, $urandom}; pre_req = 1'b1; en_cnt = 0; start = 1'b1;
    @(negedge clk);
    pre_req = 1'b0; start = 1'b0;
    send_word(1'b0, $urandom, 0);
    n = 0;
    while (en_cnt < 17 && n < TMO) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    check("pre_reset_count", bit_count, 17);
    #2 rst_n = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check("arst_en", en, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_count", bit_count, 0);
    check("arst_rb_data", rb_data, 0);
    check("arst_head", head, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_load({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1'b0, 1'b0);

    // Partial final word on the 40-bit chain.
    run_load_p(32'hFFFF_FFFF, 32'hFFFF_FF3C, {8'h5A, 32'h1357_9BDF});
    run_load_p($urandom, $urandom, {8'($urandom), 32'($urandom)});

    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      p = {$urandom, $urandom};
      run_load(d, p, $urandom_range(0, 6), $urandom_range(0, 6),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver that sits directly upstream of the grid tiles' ccff_head input.
- Accepts configuration bitstream words over a valid/ready interface and serializes them LSB-first onto ccff_head, one bit per enabled prog_clk cycle.
- Drives a chain-advance enable (ccff_clk_en) and captures the bits emerging from the far ccff_tail as readback words.
- Stops after exactly CHAIN_LEN bits.

Parameters:
- WORD_W, 32, bitstream/readback word width (>=2).
- CHAIN_LEN, 64, total configuration flops in the chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of bit counter.

Ports:
- prog_clk  input  1  configuration clock; all state on rising edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin a load; honoured only in IDLE or DONE.
- cfg_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial data into the chain head (registered).
- ccff_clk_en  output  1  chain advances at the end of this cycle (registered, feeds the prog_clk gate).
- ccff_tail  input  1  serial data from the chain tail.
- rb_data  output  WORD_W  readback word, first tail bit at bit 0.
- rb_valid  output  1  one-cycle pulse, rb_data valid; no backpressure.
- busy  output  1  state == SHIFT.
- done  output  1  high in DONE.
- bit_count  output  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (async, any time, including mid-load):
  - state = IDLE.
  - ccff_head, ccff_clk_en, cfg_ready, rb_valid, done, busy = 0.
  - bit_count, rb_data, word buffer, buffer count = 0.
  - The chain contents are undefined after a mid-load reset; a full reload is required.
- States: IDLE, SHIFT, DONE.
  - IDLE --start--> SHIFT. bit_count is cleared on entry.
  - DONE --start--> SHIFT. done drops the cycle after start is sampled.
  - SHIFT --(bit_count reaches CHAIN_LEN)--> DONE.
  - start is ignored while in SHIFT.
- Word buffer: data register plus buf_cnt (0..WORD_W).
  - cfg_ready = (state==SHIFT) && (buf_cnt==0) && (bit_count < CHAIN_LEN). Combinational from registers only.
  - Handshake cfg_valid && cfg_ready loads the buffer. buf_cnt = min(WORD_W, CHAIN_LEN - bit_count).
  - For the final word, unused high bits of cfg_data are ignored.
  - One bubble cycle per word is permitted: no shifting occurs in the accept cycle.
- Shift cycle, whenever state==SHIFT and buf_cnt != 0:
  - ccff_head presents buffer bit 0 and ccff_clk_en = 1. Both are driven from registers, so they are valid the whole cycle.
  - At the closing edge: buffer shifts right by 1, buf_cnt decrements, bit_count increments.
  - At the same edge, ccff_tail is sampled into the readback accumulator, taking the pre-shift tail value.
- Starvation: when buf_cnt == 0 (including cfg_valid low), ccff_clk_en = 0 and ccff_head holds its last value. The chain does not advance.
- Readback:
  - Tail bits fill the accumulator from bit 0 upward.
  - rb_valid pulses in the cycle after the WORD_W-th captured bit, or after the final bit of the load (partial word, unused high bits zero).
  - Readback words per load = ceil(CHAIN_LEN / WORD_W).
- Completion:
  - The shift cycle with bit_count == CHAIN_LEN-1 is the last one.
  - Next cycle: state = DONE, done = 1, ccff_clk_en = 0, cfg_ready = 0.
  - bit_count holds CHAIN_LEN until the next start.
  - Extra cfg_valid beyond CHAIN_LEN bits is never accepted.
- Counters never wrap: bit_count saturates at CHAIN_LEN.

Test Plan:
- Full load: CHAIN_LEN=64, WORD_W=32, words 0xA5A5_0001 then 0x8000_00FF, cfg_valid held high, behavioural 64-flop chain model -> exactly 64 ccff_clk_en cycles; chain equals {0x8000_00FF, 0xA5A5_0001}; done=1 one cycle after the last shift; bit_count=64.
- Partial final word: CHAIN_LEN=40, WORD_W=32, words 0xFFFF_FFFF, 0xFFFF_FF3C -> 40 shifts; last 8 bits 0x3C; only 2 words accepted; third cfg_valid sees cfg_ready=0.
- Backpressure/starvation: drop cfg_valid for 5 cycles between words -> ccff_clk_en=0 for those cycles; ccff_head stable; final chain contents unchanged vs. the back-to-back case.
- Readback: chain preloaded 0x0123_4567_89AB_CDEF (tail end = LSB), load any data -> rb_valid pulses twice, rb_data = 0x89AB_CDEF then 0x0123_4567.
- Reset mid-load: assert prog_reset_n low after 17 shifts -> outputs 0 immediately (asynchronous); after release, start reloads from bit_count 0 and completes 64 shifts.
- Restart and ignored start: pulse start in SHIFT -> no effect; start in DONE -> done falls, new 64-bit load completes correctly.
